// File: rtl/hdmi_acr_meter.sv
// hdmi_acr_meter: measures the async audio clock against the pixel clock and
// produces HDMI ACR values: a constant N and a measured CTS, plus lock/error status.
// Ports: I_clk_pixel, I_reset (async, active-high), I_clk_audio (async),
//        I_acr_ready / O_acr_valid / O_cts (valid/ready handshake), O_n (constant N),
//        O_sample_strobe (one pulse per audio edge), O_locked, O_error (sticky).
// Optional: define ACR_FIXED_CTS_EN to report CTS_NOMINAL instead of the measured CTS.
module hdmi_acr_meter #(
    parameter int N_VALUE       = 6144,
    parameter int CTS_WIDTH     = 20,
    parameter int CTS_NOMINAL   = 27000,
    parameter int CTS_TOLERANCE = 32
) (
    input  logic                 I_clk_pixel,
    input  logic                 I_reset,
    input  logic                 I_clk_audio,
    input  logic                 I_acr_ready,
    output logic                 O_acr_valid,
    output logic [CTS_WIDTH-1:0] O_cts,
    output logic [19:0]          O_n,
    output logic                 O_sample_strobe,
    output logic                 O_locked,
    output logic                 O_error
);

    localparam int WIN = N_VALUE / 128;
    localparam int EW  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int LO  = (CTS_NOMINAL > CTS_TOLERANCE) ? CTS_NOMINAL - CTS_TOLERANCE : 0;
    localparam int HI  = CTS_NOMINAL + CTS_TOLERANCE;
    localparam logic [CTS_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t               state, state_d;
    logic                 sync1, sync2, sync3;
    logic                 aud_edge;
    logic [CTS_WIDTH-1:0] pix_cnt, pix_d;
    logic [EW-1:0]        edge_cnt, ecnt_d;
    logic [1:0]           lock_cnt, lock_d;
    logic                 valid_d, err_d;
    logic [CTS_WIDTH-1:0] cts_d, capture;
    logic                 boundary, timeout, in_tol;

    assign O_n      = 20'(N_VALUE);
    assign O_locked = (lock_cnt == 2'd2);
    assign aud_edge = sync2 & ~sync3;

    // Tolerance window is checked against the measured count in every build.
    assign in_tol = ({1'b0, pix_cnt} >= (CTS_WIDTH+1)'(LO)) &&
                    ({1'b0, pix_cnt} <= (CTS_WIDTH+1)'(HI));

`ifdef ACR_FIXED_CTS_EN
    assign capture = CTS_WIDTH'(CTS_NOMINAL);
`else
    assign capture = pix_cnt;
`endif

    always_ff @(posedge I_clk_pixel or posedge I_reset) begin
        if (I_reset) begin
            sync1           <= 1'b0;
            sync2           <= 1'b0;
            sync3           <= 1'b0;
            O_sample_strobe <= 1'b0;
        end else begin
            sync1           <= I_clk_audio;
            sync2           <= sync1;
            sync3           <= sync2;
            O_sample_strobe <= aud_edge;
        end
    end

    always_ff @(posedge I_clk_pixel or posedge I_reset) begin
        if (I_reset) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            edge_cnt    <= '0;
            lock_cnt    <= 2'd0;
            O_acr_valid <= 1'b0;
            O_cts       <= '0;
            O_error     <= 1'b0;
        end else begin
            state       <= state_d;
            pix_cnt     <= pix_d;
            edge_cnt    <= ecnt_d;
            lock_cnt    <= lock_d;
            O_acr_valid <= valid_d;
            O_cts       <= cts_d;
            O_error     <= err_d;
        end
    end

    always_comb begin
        state_d  = state;
        pix_d    = pix_cnt;
        ecnt_d   = edge_cnt;
        boundary = 1'b0;
        timeout  = 1'b0;
        unique case (state)
            IDLE: begin
                if (aud_edge) begin
                    state_d = MEASURE;
                    pix_d   = CTS_WIDTH'(1);
                    ecnt_d  = '0;
                end
            end
            MEASURE: begin
                // Counter saturation means the audio clock vanished.
                if (pix_cnt == CNT_MAX) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                    pix_d   = '0;
                    ecnt_d  = '0;
                end else begin
                    pix_d = pix_cnt + CTS_WIDTH'(1);
                    if (aud_edge) begin
                        if (edge_cnt == EW'(WIN - 1)) begin
                            boundary = 1'b1;
                            pix_d    = CTS_WIDTH'(1);
                            ecnt_d   = '0;
                        end else begin
                            ecnt_d = edge_cnt + EW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = O_acr_valid;
        cts_d   = O_cts;
        lock_d  = lock_cnt;
        err_d   = O_error;
        if (O_acr_valid && I_acr_ready)
            valid_d = 1'b0;
        if (timeout) begin
            lock_d = 2'd0;
            err_d  = 1'b1;
        end
        if (boundary) begin
            valid_d = 1'b1;
            cts_d   = capture;
            // Unread value being replaced without a transfer is an overrun.
            if (O_acr_valid && !I_acr_ready)
                err_d = 1'b1;
            if (in_tol) begin
                lock_d = (lock_cnt == 2'd2) ? 2'd2 : lock_cnt + 2'd1;
            end else begin
                lock_d = 2'd0;
                err_d  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_acr_meter.sv
// tb_hdmi_acr_meter: directed bench for hdmi_acr_meter with a shortened window
// (N=1024 -> 8 audio edges per window, 13-bit CTS) to keep run time small.
module tb_hdmi_acr_meter;

    localparam int NV  = 1024;
    localparam int CW  = 13;
    localparam int NOM = 4496;
    localparam int TOL = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          aud = 1'b0;
    logic          ready = 1'b0;
    logic          valid;
    logic [CW-1:0] cts;
    logic [19:0]   n_out;
    logic          strobe;
    logic          locked;
    logic          err;

    int nchk  = 0;
    int nfail = 0;

    int per    = 562;
    bit aud_en = 1'b0;
    int acnt   = 561;
    int anxt;

    typedef struct {
        int per;
        int cts;
        int lck;
        int err;
    } vec_t;

    vec_t tab[5];

    hdmi_acr_meter #(
        .N_VALUE(NV),
        .CTS_WIDTH(CW),
        .CTS_NOMINAL(NOM),
        .CTS_TOLERANCE(TOL)
    ) dut (
        .I_clk_pixel(clk),
        .I_reset(rst),
        .I_clk_audio(aud),
        .I_acr_ready(ready),
        .O_acr_valid(valid),
        .O_cts(cts),
        .O_n(n_out),
        .O_sample_strobe(strobe),
        .O_locked(locked),
        .O_error(err)
    );

    always #5 clk = ~clk;

    // Audio clock changes on the pixel negedge; the period is read live.
    always @(negedge clk) begin
        if (!aud_en) begin
            aud  <= 1'b0;
            acnt <= per - 1;
        end else begin
            anxt = (acnt >= per - 1) ? 0 : acnt + 1;
            acnt <= anxt;
            aud  <= (anxt < per / 2);
        end
    end

    function automatic int ects(input int m);
`ifdef ACR_FIXED_CTS_EN
        return NOM;
`else
        return m;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input int limit, output int strobes);
        strobes = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (strobe) strobes++;
            if (valid) return;
        end
        nchk++;
        nfail++;
        $display("FAIL wait_valid: got timeout expected valid within %0d", limit);
    endtask

    task automatic wait_strobes(input int cnt, input int limit);
        int s;
        s = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (strobe) s++;
            if (s == cnt) return;
        end
        nchk++;
        nfail++;
        $display("FAIL wait_strobes: got %0d expected %0d", s, cnt);
    endtask

    task automatic consume();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("consume_valid", valid, 0);
    endtask

    task automatic reset_pulse();
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_cts", cts, 0);
        chk("rst_strobe", strobe, 0);
        chk("rst_locked", locked, 0);
        chk("rst_error", err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int s;
        tab[0] = '{566, 4528, 1, 0};
        tab[1] = '{558, 4464, 1, 0};
        tab[2] = '{567, 4536, 0, 1};
        tab[3] = '{562, 4496, 0, 1};
        tab[4] = '{562, 4496, 1, 1};

        repeat (3) @(negedge clk);
        chk("init_valid", valid, 0);
        chk("init_cts", cts, 0);
        chk("init_locked", locked, 0);
        chk("init_error", err, 0);
        chk("init_n", n_out, NV);
        rst = 1'b0;
        @(negedge clk);
        aud_en = 1'b1;

        // First window and lock after two in-tolerance windows.
        wait_valid(6000, s);
        chk("first_strobes", s, 9);
        chk("first_cts", cts, ects(4496));
        chk("first_n", n_out, NV);
        chk("first_locked", locked, 0);
        chk("first_error", err, 0);
        consume();
        wait_valid(6000, s);
        chk("second_cts", cts, ects(4496));
        chk("second_locked", locked, 1);
        chk("second_error", err, 0);

        // Ready asserted exactly in the boundary cycle.
        per = 563;
        repeat (4503) @(posedge clk);
        #1;
        chk("pre_xfer_cts", cts, ects(4496));
        chk("pre_xfer_valid", valid, 1);
        ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        @(negedge clk);
        chk("xfer_valid", valid, 1);
        chk("xfer_cts", cts, ects(4504));
        chk("xfer_error", err, 0);
        chk("xfer_locked", locked, 1);

        // Overrun: new value lands while the previous one is unread.
        per = 562;
        wait_strobes(8, 6000);
        chk("ovr_valid", valid, 1);
        chk("ovr_cts", cts, ects(4496));
        chk("ovr_error", err, 1);
        chk("ovr_locked", locked, 1);

        // Reset in the middle of a window, with the audio clock low.
        repeat (300) @(negedge clk);
        reset_pulse();
        wait_valid(6000, s);
        chk("postrst_strobes", s, 9);
        chk("postrst_cts", cts, ects(4496));
        chk("postrst_locked", locked, 0);
        chk("postrst_error", err, 0);

        // Tolerance edges and out-of-tolerance windows.
        for (int i = 0; i < 5; i++) begin
            consume();
            per = tab[i].per;
            wait_strobes(8, 6000);
            chk($sformatf("tab%0d_cts", i), cts, ects(tab[i].cts));
            chk($sformatf("tab%0d_locked", i), locked, tab[i].lck);
            chk($sformatf("tab%0d_error", i), err, tab[i].err);
            chk($sformatf("tab%0d_valid", i), valid, 1);
        end

        // Audio clock stops while locked, then restarts.
        repeat (300) @(negedge clk);
        reset_pulse();
        wait_valid(6000, s);
        consume();
        wait_valid(6000, s);
        chk("prestop_locked", locked, 1);
        aud_en = 1'b0;
        repeat (8000) @(negedge clk);
        chk("stopped_locked", locked, 1);
        chk("stopped_error", err, 0);
        repeat (300) @(negedge clk);
        chk("timeout_locked", locked, 0);
        chk("timeout_error", err, 1);
        consume();
        aud_en = 1'b1;
        wait_valid(6000, s);
        chk("restart1_strobes", s, 9);
        chk("restart1_cts", cts, ects(4496));
        chk("restart1_locked", locked, 0);
        consume();
        wait_valid(6000, s);
        chk("restart2_locked", locked, 1);
        chk("restart2_error", err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/hdmi_acr_meter.md
# hdmi_acr_meter

Measures the asynchronous 48 kHz audio clock from the clock generator against the pixel clock and produces HDMI Audio Clock Regeneration values: N (constant) and CTS (measured pixel cycles per N/128 audio periods). It runs entirely in the pixel clock domain. It sits between the clock generator and the HDMI audio/ACR packet generator. It also emits a per-sample strobe for the audio sample path.

## Interface
- N_VALUE, 6144: HDMI N for 48 kHz; window length is N_VALUE/128 audio edges (48).
- CTS_WIDTH, 20: width of CTS and of the pixel-cycle counter.
- CTS_NOMINAL, 27000: expected CTS (27000 for 480p, 74250 for 720p).
- CTS_TOLERANCE, 32: maximum allowed |measured − CTS_NOMINAL| for lock.
- I_clk_pixel  in  1  pixel clock; the only clock.
- I_reset  in  1  asynchronous, active-high reset.
- I_clk_audio  in  1  audio clock, asynchronous to I_clk_pixel.
- I_acr_ready  in  1  packet generator accepts O_cts this cycle.
- O_acr_valid  out  1  O_cts holds an unconsumed value.
- O_cts  out  CTS_WIDTH  CTS value.
- O_n  out  20  constant N_VALUE.
- O_sample_strobe  out  1  one-cycle pulse per audio rising edge.
- O_locked  out  1  CTS within tolerance for 2 consecutive windows.
- O_error  out  1  sticky fault flag: out-of-tolerance, overrun, or timeout.

## Operation
- Input path: 2-flop synchronizer on I_clk_audio, then an edge register. A rising edge gives `edge` for one cycle. O_sample_strobe is registered `edge`.
- FSM states:
  - IDLE: wait for `edge`. On `edge`, go to MEASURE with pix_cnt=1 and edge_cnt=0.
  - MEASURE: pix_cnt increments each cycle. Each `edge` increments edge_cnt. At the edge where edge_cnt==N_VALUE/128−1, the cycle is a boundary.
- Boundary actions:
  - Capture pix_cnt into O_cts.
  - Set pix_cnt to 1 and edge_cnt to 0.
  - Evaluate tolerance.
- With audio period P cycles, the captured value is 48·P.
- Timeout/overflow: if pix_cnt reaches 2^CTS_WIDTH−1 in MEASURE:
  - go to IDLE;
  - clear O_locked and lock_cnt;
  - set O_error;
  - make no capture.
- Lock:
  - A 2-bit lock_cnt increments on each in-tolerance boundary, saturating at 2. O_locked=1 when lock_cnt==2.
  - An out-of-tolerance boundary clears lock_cnt and O_locked and sets O_error.
- Handshake:
  - A boundary sets O_acr_valid=1.
  - A transfer occurs in any cycle with O_acr_valid && I_acr_ready. A transfer clears O_acr_valid unless a boundary occurs in the same cycle.
  - Boundary with valid high and no ready: O_cts is overwritten with the new value, valid stays 1, and O_error is set (overrun).
  - Boundary and transfer in the same cycle: the old value transfers, the new value loads, valid stays 1, and no error is raised.
- O_error clears only on reset.

## Timing
- Reset values: O_acr_valid=0, O_cts=0, O_sample_strobe=0, O_locked=0, O_error=0, FSM=IDLE, counters=0. O_n is always N_VALUE.
- Reset is asynchronous: assertion mid-window clears state immediately. After deassertion, the first capture comes 48 edges after the first post-reset edge.
- O_sample_strobe goes high 3–4 I_clk_pixel cycles after the I_clk_audio rising edge (synchronizer uncertainty).
- O_cts and O_acr_valid update on the clock after the boundary `edge` cycle.
- O_locked and O_error update in the same cycle as O_cts.

## Configuration
- ACR_FIXED_CTS_EN defined: at each boundary, O_cts loads CTS_NOMINAL instead of the measured value. The measurement, lock, error and handshake logic are unchanged and still use the measured value.
- ACR_FIXED_CTS_EN undefined: O_cts carries the measured value.

## Test plan
- Audio period 562 cycles (27 MHz pixel clock, divider 281):
  - first O_acr_valid 48 edges after the first edge, with O_cts=26976 and O_n=6144;
  - O_locked=1 after the second boundary;
  - O_error=0.
- I_acr_ready held low over two boundaries:
  - O_cts shows the second value;
  - O_acr_valid stays 1;
  - O_error=1.
  - Ready pulsed in a boundary cycle: new value held, valid=1, no error.
- Audio period 600 cycles: O_cts=28800, O_locked=0, O_error=1.
- Audio clock stopped while locked:
  - after 2^20−1 cycles, FSM returns to IDLE, O_locked=0, O_error=1;
  - restart at period 562: O_locked=1 again after 2 boundaries.
- I_reset pulsed mid-window: all outputs 0 asynchronously; first capture 48 edges after the first post-reset edge.
- ACR_FIXED_CTS_EN defined, period 562: O_cts=27000, O_locked=1.
